// File: rtl/edge_row_scanner.sv
// Purpose: finds horizontal intensity edges on one selected row per frame and publishes their x list.
// Latency: list_valid pulses the cycle after the clk edge that accepts pixel IMAGE_W-1 of the scan row.
// Backpressure: none; in_valid=0 beats freeze state and pipeline, outputs hold between publishes.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   in_valid, sop          pixel beat valid, start of packet (qualified by in_valid)
//   packet_video           current packet carries video (meaningful from the beat after sop)
//   x, y                   pixel column / row counters
//   red, green, blue       pixel components
//   edge_row, threshold    row to scan and gradient threshold, captured at each sop
//   edge_list              published list, entry k at bits [11k+10:11k], unused = EMPTY_CODE
//   edge_count             number of valid entries in edge_list
//   list_valid             one-cycle pulse when a new list is published
//   overflow               last published row had more than MAX_EDGES candidates
module edge_row_scanner #(
    parameter int          IMAGE_W    = 640,
    parameter int          MAX_EDGES  = 30,
    parameter int          MIN_GAP    = 4,
    parameter logic [10:0] EMPTY_CODE = 11'h7FF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic                     sop,
    input  logic                     packet_video,
    input  logic [10:0]              x,
    input  logic [10:0]              y,
    input  logic [7:0]               red,
    input  logic [7:0]               green,
    input  logic [7:0]               blue,
    input  logic [10:0]              edge_row,
    input  logic [7:0]               threshold,
    output logic [11*MAX_EDGES-1:0]  edge_list,
    output logic [4:0]               edge_count,
    output logic                     list_valid,
    output logic                     overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SCAN,
        S_PUBLISH
    } state_t;

    state_t      state;
    logic [10:0] row_q;
    logic [7:0]  thr_q;
    logic [7:0]  grey_d1;
    logic [7:0]  grey_d2;
    logic [10:0] work_list [MAX_EDGES];
    logic [4:0]  work_cnt;
    logic        work_ovf;
    logic [10:0] last_x;

    logic [7:0]  grey;
    logic [7:0]  grad;
    logic        restart;
    logic        start_hit;
    logic        process;
    logic        cand;
    logic        room;
    logic        gap_ok;
    logic        accept;
    logic        last_beat;
    logic        ovf_next;
    logic [4:0]  cnt_next;
    logic [10:0] work_next [MAX_EDGES];

    // Weighted sum peaks at 127+63+63 = 253, so 8 bits never wrap.
    assign grey = {1'b0, green[7:1]} + {2'b00, red[7:2]} + {2'b00, blue[7:2]};
    assign grad = (grey >= grey_d2) ? (grey - grey_d2) : (grey_d2 - grey);

    // A valid sop restarts the frame from any state; it always wins over pixel processing.
    assign restart   = in_valid && sop;
    assign start_hit = (state == S_WAIT) && (y == row_q) && (x == 11'd0);
    assign process   = in_valid && !sop && ((state == S_SCAN) || start_hit);

    assign cand      = process && (x >= 11'd2) && (grad > thr_q);
    assign room      = work_cnt < 5'(MAX_EDGES);
    // Columns only increase along a row, so the unsigned difference is the true gap.
    assign gap_ok    = (work_cnt == 5'd0) || ((x - last_x) >= 11'(MIN_GAP));
    assign accept    = cand && room && gap_ok;
    assign ovf_next  = work_ovf || (cand && !room);
    assign cnt_next  = work_cnt + {4'd0, accept};
    assign last_beat = process && (x == 11'(IMAGE_W - 1));

    // Working list as it stands after this beat, so the final pixel's edge is published too.
    always_comb begin
        work_next = work_list;
        for (int k = 0; k < MAX_EDGES; k++) begin
            if (accept && (work_cnt == 5'(k))) begin
                work_next[k] = x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            row_q      <= 11'd0;
            thr_q      <= 8'd0;
            grey_d1    <= 8'd0;
            grey_d2    <= 8'd0;
            for (int k = 0; k < MAX_EDGES; k++) begin
                work_list[k] <= EMPTY_CODE;
            end
            work_cnt   <= 5'd0;
            work_ovf   <= 1'b0;
            last_x     <= 11'd0;
            edge_list  <= {MAX_EDGES{EMPTY_CODE}};
            edge_count <= 5'd0;
            list_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            list_valid <= 1'b0;
            if (restart) begin
                row_q    <= edge_row;
                thr_q    <= threshold;
                for (int k = 0; k < MAX_EDGES; k++) begin
                    work_list[k] <= EMPTY_CODE;
                end
                work_cnt <= 5'd0;
                work_ovf <= 1'b0;
                state    <= S_ARM;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_ARM: begin
                        if (in_valid) begin
                            state <= packet_video ? S_WAIT : S_IDLE;
                        end
                    end
                    S_WAIT, S_SCAN: begin
                        if (process) begin
                            work_list <= work_next;
                            work_cnt  <= cnt_next;
                            work_ovf  <= ovf_next;
                            if (accept) begin
                                last_x <= x;
                            end
                            grey_d2 <= grey_d1;
                            grey_d1 <= grey;
                            if (last_beat) begin
                                // Outputs update on this edge so they are already
                                // valid during the list_valid cycle.
                                for (int k = 0; k < MAX_EDGES; k++) begin
                                    edge_list[11*k +: 11] <= work_next[k];
                                end
                                edge_count <= cnt_next;
                                overflow   <= ovf_next;
                                list_valid <= 1'b1;
                                state      <= S_PUBLISH;
                            end else begin
                                state <= S_SCAN;
                            end
                        end
                    end
                    S_PUBLISH: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_edge_row_scanner.sv
module tb_edge_row_scanner;

    localparam int W  = 640;
    localparam int N  = 30;
    localparam int LW = 11 * N;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          sop;
    logic          packet_video;
    logic [10:0]   x;
    logic [10:0]   y;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;
    logic [10:0]   edge_row;
    logic [7:0]    threshold;
    logic [LW-1:0] edge_list;
    logic [4:0]    edge_count;
    logic          list_valid;
    logic          overflow;

    always #5 clk = ~clk;

    edge_row_scanner dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .sop          (sop),
        .packet_video (packet_video),
        .x            (x),
        .y            (y),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .edge_row     (edge_row),
        .threshold    (threshold),
        .edge_list    (edge_list),
        .edge_count   (edge_count),
        .list_valid   (list_valid),
        .overflow     (overflow)
    );

    int            checks    = 0;
    int            fails     = 0;
    int            lv_pulses = 0;
    logic [7:0]    pr [W];
    logic [7:0]    pg [W];
    logic [7:0]    pb [W];
    logic [LW-1:0] exp_list;
    int            exp_cnt;
    bit            exp_ovf;
    logic [LW-1:0] empty_list;

    always @(posedge clk) begin
        if (list_valid === 1'b1) lv_pulses++;
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: greedy left-to-right scan of |grey(x)-grey(x-2)| with the gap / capacity rules.
    function automatic void model(input int thr);
        int gr [W];
        int last;
        int d;
        for (int i = 0; i < W; i++) gr[i] = int'(pg[i] >> 1) + int'(pr[i] >> 2) + int'(pb[i] >> 2);
        exp_list = empty_list;
        exp_cnt  = 0;
        exp_ovf  = 0;
        last     = 0;
        for (int xi = 2; xi < W; xi++) begin
            d = gr[xi] - gr[xi-2];
            if (d < 0) d = -d;
            if (d > thr) begin
                if (exp_cnt == N) exp_ovf = 1;
                else if (exp_cnt == 0 || xi - last >= 4) begin
                    exp_list[11*exp_cnt +: 11] = 11'(xi);
                    exp_cnt++;
                    last = xi;
                end
            end
        end
    endfunction

    task automatic fill(input logic [7:0] v, input int from, input int to);
        for (int i = from; i < to; i++) begin
            pr[i] = v; pg[i] = v; pb[i] = v;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 0; sop = 0;
        end
    endtask

    task automatic beat(input bit s, input int bx, input int by, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b, input bit pv, input bit stall);
        while (stall && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            in_valid = 0;
            sop      = 1'($urandom_range(0, 1));
            x        = 11'($urandom_range(0, W-1));
            y        = 11'(215);
            red      = 8'($urandom);
            green    = 8'($urandom);
            blue     = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1; sop = s; x = 11'(bx); y = 11'(by);
        red = r; green = g; blue = b; packet_video = pv;
    endtask

    task automatic run_frame(input int row, input int thr, input bit pv, input bit stall,
                             input int abort_x, input string tag);
        int p0;
        bit pub;
        edge_row  = 11'(row);
        threshold = 8'(thr);
        p0  = lv_pulses;
        pub = pv && (row == 215) && (abort_x < 0);
        beat(1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), !pv, 0);
        for (int i = 630; i < W; i++)
            beat(0, i, 214, 8'($urandom), 8'($urandom), 8'($urandom), pv, stall);
        for (int i = 0; i < W; i++) begin
            if (i == abort_x) begin
                beat(1, i, 215, pr[i], pg[i], pb[i], pv, 0);
                idle(3);
                check({tag, "_abort_pulses"}, LW'(lv_pulses - p0), LW'(0));
                return;
            end
            beat(0, i, 215, pr[i], pg[i], pb[i], pv, stall);
        end
        if (pub) model(thr);
        @(negedge clk);
        check({tag, "_lv_latency"}, LW'(list_valid), LW'(pub));
        in_valid = 0; sop = 0;
        @(negedge clk);
        check({tag, "_lv_one_cycle"}, LW'(list_valid), LW'(0));
        for (int i = 0; i < 4; i++)
            beat(0, i, 216, 8'($urandom), 8'($urandom), 8'($urandom), pv, 0);
        idle(2);
        check({tag, "_pulses"}, LW'(lv_pulses - p0), LW'(pub));
        check({tag, "_count"}, LW'(edge_count), LW'(exp_cnt));
        check({tag, "_ovf"}, LW'(overflow), LW'(exp_ovf));
        check({tag, "_list"}, edge_list, exp_list);
    endtask

    initial begin
        int p0;
        empty_list = {N{11'h7FF}};
        reset_n = 0; in_valid = 0; sop = 0; packet_video = 0;
        x = 0; y = 0; red = 0; green = 0; blue = 0; edge_row = 0; threshold = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        check("rst_count", LW'(edge_count), LW'(0));
        check("rst_lv", LW'(list_valid), LW'(0));
        check("rst_ovf", LW'(overflow), LW'(0));
        check("rst_list", edge_list, empty_list);
        exp_list = empty_list; exp_cnt = 0; exp_ovf = 0;

        // Single step at 100; 101 lies inside the gap
        fill(8'h20, 0, 100); fill(8'hE0, 100, W);
        run_frame(215, 40, 1, 0, -1, "step100");
        check("step100_e0", LW'(edge_list[10:0]), LW'(100));
        check("step100_e1", LW'(edge_list[21:11]), LW'(11'h7FF));

        // Steps at 50, 52, 60: 52 rejected by the gap
        fill(8'h20, 0, W); fill(8'hE0, 50, 52); fill(8'hE0, 60, W);
        run_frame(215, 40, 1, 0, -1, "steps3");
        check("steps3_e0", LW'(edge_list[10:0]), LW'(50));
        check("steps3_e1", LW'(edge_list[21:11]), LW'(60));
        check("steps3_cnt", LW'(edge_count), LW'(2));

        // Alternating blocks of 4 overflow the list
        for (int i = 0; i < W; i++) begin
            pr[i] = ((i / 4) % 2 == 1) ? 8'hFF : 8'h00;
            pg[i] = pr[i]; pb[i] = pr[i];
        end
        run_frame(215, 40, 1, 0, -1, "alt");
        check("alt_cnt", LW'(edge_count), LW'(30));
        check("alt_ovf", LW'(overflow), LW'(1));
        check("alt_e0", LW'(edge_list[10:0]), LW'(4));
        check("alt_e29", LW'(edge_list[329:319]), LW'(120));

        // Abort mid-scan, then a clean frame
        fill(8'h20, 0, 400); fill(8'hE0, 400, W);
        run_frame(215, 40, 1, 0, 300, "abort");
        run_frame(215, 40, 1, 0, -1, "after_abort");
        check("after_abort_e0", LW'(edge_list[10:0]), LW'(400));

        // Non-video packet ignored, then stalled video frame
        fill(8'h00, 0, 150); fill(8'hFF, 150, W);
        run_frame(215, 40, 0, 0, -1, "nonvideo");
        fill(8'h20, 0, 200); fill(8'hE0, 200, W);
        run_frame(215, 40, 1, 1, -1, "stall");
        check("stall_e0", LW'(edge_list[10:0]), LW'(200));

        // Row beyond frame height never publishes
        run_frame(480, 40, 1, 0, -1, "farrow");

        // Random piecewise-constant rows, random threshold, random stalls
        for (int f = 0; f < 5; f++) begin
            logic [7:0] vr, vg, vb;
            vr = 8'($urandom); vg = 8'($urandom); vb = 8'($urandom);
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 11) == 0) begin
                    vr = 8'($urandom); vg = 8'($urandom); vb = 8'($urandom);
                end
                pr[i] = vr; pg[i] = vg; pb[i] = vb;
            end
            run_frame(215, $urandom_range(0, 80), 1, 1'($urandom_range(0, 1)), -1, "rand");
        end

        // Reset in the middle of the scan row
        p0 = lv_pulses;
        edge_row = 11'(215); threshold = 8'(10);
        beat(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) beat(0, i, 215, pr[i], pg[i], pb[i], 1, 0);
        @(negedge clk);
        reset_n = 0; in_valid = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        check("midrst_count", LW'(edge_count), LW'(0));
        check("midrst_ovf", LW'(overflow), LW'(0));
        check("midrst_list", edge_list, empty_list);
        for (int i = 300; i < W; i++) beat(0, i, 215, pr[i], pg[i], pb[i], 1, 0);
        idle(4);
        check("midrst_pulses", LW'(lv_pulses - p0), LW'(0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/edge_row_scanner.md
Name: edge_row_scanner

Overview:
- Scans one configurable video row per frame and finds horizontal intensity edges.
- Builds a fixed-size list of edge x-coordinates and publishes it once per frame for the overlay and measurement logic in the image-processing stage.
- Sits directly upstream of that stage, in parallel with the pixel path. It takes the same buffered pixel stream, the x/y counters and the packet_video flag.
- Drives the measured edge list that the downstream stage copies for drawing and reporting.

Parameters:
- IMAGE_W, 640: pixels per row; the last column is IMAGE_W-1.
- MAX_EDGES, 30: number of list entries.
- MIN_GAP, 4: minimum x spacing between accepted edges.
- EMPTY_CODE, 11'h7FF: value placed in unused list entries; it never matches a valid x.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  pixel valid for the current beat
- sop  in  1  start of packet, qualified by in_valid
- packet_video  in  1  current packet is video; valid from the beat after sop
- x  in  11  column of the current pixel
- y  in  11  row of the current pixel
- red, green, blue  in  8 each  pixel components
- edge_row  in  11  row to scan; sampled at each sop
- threshold  in  8  gradient threshold; sampled at each sop
- edge_list  out  11*MAX_EDGES  published list, packed with entry k at bits [11k+10:11k]
- edge_count  out  5  number of valid entries in edge_list
- list_valid  out  1  one-cycle pulse when a new list is published
- overflow  out  1  last published row had more than MAX_EDGES candidates

Behaviour:
- Reset, clk edge with reset_n=0:
  - state=IDLE.
  - All edge_list entries and all working entries = EMPTY_CODE.
  - edge_count=0, list_valid=0, overflow=0.
  - Reset mid-row discards the working list; nothing is published.
- Greyscale: grey = green[7:1] + red[7:2] + blue[7:2], as 8-bit unsigned (maximum 253, no overflow).
- Gradient on accepted beats of the scan row: g = |grey(x) - grey(x-2)|.
  - Uses two registered previous-grey stages.
  - Evaluated only for x >= 2.
  - Candidate when g > threshold (strict).
- Acceptance:
  - A candidate is accepted if working count < MAX_EDGES and either no edge has been accepted yet this row or x - last_x >= MIN_GAP.
  - On acceptance: entry[count] <= x, count++, last_x <= x, all on the clk edge of that beat.
  - A candidate arriving at count == MAX_EDGES sets the working overflow bit and is dropped.
- FSM:
  - IDLE:
    - On sop&in_valid: latch edge_row and threshold; go to ARM.
    - Working list, count and overflow are cleared to EMPTY_CODE/0.
  - ARM:
    - On the next in_valid beat, if packet_video=0 go to IDLE (non-video packet ignored).
    - If packet_video=1 go to WAIT.
  - WAIT: when in_valid and y == latched row and x == 0, go to SCAN; this beat is processed.
  - SCAN: process each in_valid beat. On in_valid with x == IMAGE_W-1, go to PUBLISH.
  - PUBLISH, one cycle:
    - edge_list <= working list; edge_count <= count; overflow <= working overflow.
    - list_valid=1 for exactly this cycle.
    - Go to IDLE.
- Latency: list_valid asserts on the cycle after the clk edge that accepts pixel x=IMAGE_W-1 of the scan row.
- sop&in_valid in any state other than IDLE aborts the current frame. It re-enters the IDLE-on-sop action in the same cycle, so the working list is cleared and the new row/threshold latched. The previous published list is retained.
- in_valid=0 beats: no state, gradient or pipeline change (pipeline stalls cleanly).
- If the latched row >= frame height, the row is never reached; no publish occurs and the outputs hold the previous list.
- Outputs are stable between list_valid pulses.
- The downstream stage may copy edge_list at any time, with no handshake.

Test Plan:
1. Reset, then hold.
   - Required: edge_count=0, list_valid=0, overflow=0, every edge_list entry = 11'h7FF.
2. Uniform grey row 215 with a step from 0x20 to 0xE0 at x=100, threshold=40.
   - Required: list_valid one cycle after x=639, edge_count=1, entry0=100.
   - Entry1 stays 7FF because x=101 falls within MIN_GAP.
3. Steps at x=50, 52, 60, same threshold.
   - Required: entries 50 and 60, edge_count=2.
   - 52 is rejected (gap 2 < 4).
4. Alternating 0x00/0xFF every 4 pixels across the row.
   - Required: edge_count=30, overflow=1.
   - Entries are the first 30 accepted x values, in ascending order.
5. sop injected at row 215, x=300 mid-scan, followed by a clean frame containing a step at x=400.
   - Required: no list_valid for the aborted frame.
   - Next frame publishes edge_count=1, entry0=400.
6. Non-video packet (packet_video=0) with a strong step on row 215, then in_valid gaps during a video frame with a step at x=200.
   - Required: no publish for the non-video packet.
   - Video frame publishes entry0=200 regardless of the stalls.
